// File: rtl/video_palwr_ctrl.sv
// Palette RAM write scheduler: default-palette init sequencer plus a buffered
// CPU write path, committing writes only while the beam is blanked.
module video_palwr_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       cpu_wr,
    input  logic [3:0] cpu_idx,
    input  logic [5:0] cpu_data,
    output logic       cpu_rdy,
    input  logic       init_start,
    output logic       pal_wr,
    output logic [3:0] pal_idx,
    output logic [5:0] pal_data,
    output logic       pal_sel,
    output logic       busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Default ZX palette: each channel is {bit, bit & bright}.
    function automatic logic [5:0] def_colour(input logic [3:0] i);
        def_colour = {i[2], i[2] & i[3], i[1], i[1] & i[3], i[0], i[0] & i[3]};
    endfunction

    state_t          state_r, state_nxt_s;
    logic [3:0]      init_idx_r, init_idx_nxt_s;
    logic [3:0]      fifo_idx_r  [FIFO_DEPTH];
    logic [5:0]      fifo_data_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r, count_nxt_s;
    logic            cpu_rdy_r;
    logic            pal_wr_r;
    logic [3:0]      pal_idx_r, pal_idx_nxt_s;
    logic [5:0]      pal_data_r, pal_data_nxt_s;

    logic            blank_s;
    logic            full_s;
    logic            push_s;
    logic            pop_s;
    logic            init_wr_s;

    assign blank_s   = hblank | vblank;
    assign full_s    = (count_r == CW'(FIFO_DEPTH));
    assign push_s    = cpu_wr & ~full_s;
    // A restart request takes the cycle, so neither source writes on it.
    assign init_wr_s = ~init_start & (state_r == ST_INIT) & blank_s;
    assign pop_s     = ~init_start & (state_r != ST_INIT) & blank_s & (count_r != CW'(0));

    // FIFO occupancy for the next cycle.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Next state and init sequencer index.
    always_comb begin
        state_nxt_s    = state_r;
        init_idx_nxt_s = init_idx_r;
        if (init_start) begin
            state_nxt_s    = ST_INIT;
            init_idx_nxt_s = 4'd0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_wr_s) begin
                        init_idx_nxt_s = init_idx_r + 4'd1;
                        if (init_idx_r == 4'd15) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_INIT;
                        end
                    end else begin
                        init_idx_nxt_s = init_idx_r;
                    end
                end
                ST_IDLE: begin
                    if (count_r != CW'(0)) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (count_nxt_s == CW'(0)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_nxt_s    = ST_INIT;
                    init_idx_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // Palette write address/data selection; held when no write is issued.
    always_comb begin
        pal_idx_nxt_s  = pal_idx_r;
        pal_data_nxt_s = pal_data_r;
        if (init_wr_s) begin
            pal_idx_nxt_s  = init_idx_r;
            pal_data_nxt_s = def_colour(init_idx_r);
        end else if (pop_s) begin
            pal_idx_nxt_s  = fifo_idx_r[rd_ptr_r];
            pal_data_nxt_s = fifo_data_r[rd_ptr_r];
        end else begin
            pal_idx_nxt_s  = pal_idx_r;
            pal_data_nxt_s = pal_data_r;
        end
    end

    // Control state, FIFO pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_INIT;
            init_idx_r <= 4'd0;
            wr_ptr_r   <= AW'(0);
            rd_ptr_r   <= AW'(0);
            count_r    <= CW'(0);
            cpu_rdy_r  <= 1'b1;
            pal_wr_r   <= 1'b0;
            pal_idx_r  <= 4'd0;
            pal_data_r <= 6'd0;
        end else begin
            state_r    <= state_nxt_s;
            init_idx_r <= init_idx_nxt_s;
            count_r    <= count_nxt_s;
            cpu_rdy_r  <= (count_nxt_s != CW'(FIFO_DEPTH));
            pal_wr_r   <= init_wr_s | pop_s;
            pal_idx_r  <= pal_idx_nxt_s;
            pal_data_r <= pal_data_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // FIFO storage; stale contents are harmless because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_idx_r[wr_ptr_r]  <= cpu_idx;
            fifo_data_r[wr_ptr_r] <= cpu_data;
        end
    end

    assign cpu_rdy  = cpu_rdy_r;
    assign pal_wr   = pal_wr_r;
    assign pal_idx  = pal_idx_r;
    assign pal_data = pal_data_r;
    assign pal_sel  = pal_wr_r;
    assign busy     = (state_r == ST_INIT) | (count_r != CW'(0));

endmodule

// File: tb/tb_video_palwr_ctrl.sv
// Directed self-checking bench for video_palwr_ctrl: init sequence, CPU FIFO
// path, blanking gating, restart and async reset.
module tb_video_palwr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       hblank, vblank;
    logic       cpu_wr;
    logic [3:0] cpu_idx;
    logic [5:0] cpu_data;
    logic       cpu_rdy;
    logic       init_start;
    logic       pal_wr;
    logic [3:0] pal_idx;
    logic [5:0] pal_data;
    logic       pal_sel;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Hand-computed default palette, index 0..15.
    logic [5:0] def_tab [16] = '{6'h00, 6'h02, 6'h08, 6'h0A, 6'h20, 6'h22, 6'h28, 6'h2A,
                                 6'h00, 6'h03, 6'h0C, 6'h0F, 6'h30, 6'h33, 6'h3C, 6'h3F};

    video_palwr_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .hblank(hblank), .vblank(vblank),
        .cpu_wr(cpu_wr), .cpu_idx(cpu_idx), .cpu_data(cpu_data), .cpu_rdy(cpu_rdy),
        .init_start(init_start), .pal_wr(pal_wr), .pal_idx(pal_idx),
        .pal_data(pal_data), .pal_sel(pal_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input string name, input logic [3:0] idx, input logic [5:0] data);
        checks++;
        if (pal_wr !== 1'b1 || pal_sel !== 1'b1 || pal_idx !== idx || pal_data !== data) begin
            errors++;
            $display("FAIL %s: got wr=%b sel=%b idx=%0d data=%h, want wr=1 sel=1 idx=%0d data=%h",
                     name, pal_wr, pal_sel, pal_idx, pal_data, idx, data);
        end
    endtask

    task automatic expect_nowr(input string name);
        checks++;
        if (pal_wr !== 1'b0 || pal_sel !== 1'b0) begin
            errors++;
            $display("FAIL %s: got wr=%b sel=%b, want wr=0 sel=0", name, pal_wr, pal_sel);
        end
    endtask

    task automatic push(input logic [3:0] idx, input logic [5:0] data);
        cpu_wr = 1'b1; cpu_idx = idx; cpu_data = data;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; hblank = 1'b1; vblank = 1'b0; cpu_wr = 1'b0;
        cpu_idx = 4'd0; cpu_data = 6'd0; init_start = 1'b0;
        #12;
        checks++;
        if (pal_wr !== 1'b0 || pal_idx !== 4'd0 || pal_data !== 6'd0 || pal_sel !== 1'b0 ||
            cpu_rdy !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset: got wr=%b idx=%0d data=%h sel=%b rdy=%b busy=%b, want 0 0 00 0 1 1",
                     pal_wr, pal_idx, pal_data, pal_sel, cpu_rdy, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_init_seq();
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_wr("init_seq", 4'(i), def_tab[i]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL init_busy: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_cpu_blank();
        hblank = 1'b0; vblank = 1'b0;
        push(4'd3, 6'h15);
        push(4'd9, 6'h2A);
        tick();
        expect_nowr("cpu_noblank");
        vblank = 1'b1;
        tick();
        expect_wr("cpu_first", 4'd3, 6'h15);
        tick();
        expect_wr("cpu_second", 4'd9, 6'h2A);
        tick();
        expect_nowr("cpu_done");
        vblank = 1'b0;
    endtask

    task automatic test_fifo_full();
        push(4'd5, 6'h11);
        push(4'd6, 6'h22);
        push(4'd7, 6'h33);
        push(4'd8, 6'h3C);
        checks++;
        if (cpu_rdy !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_rdy: got rdy=%b busy=%b, want rdy=0 busy=1", cpu_rdy, busy);
        end
        push(4'd15, 6'h3F);
        expect_nowr("full_noblank");
        hblank = 1'b1;
        tick();
        expect_wr("full_w0", 4'd5, 6'h11);
        checks++;
        if (cpu_rdy !== 1'b1) begin
            errors++;
            $display("FAIL full_rdy_back: got rdy=%b, want 1", cpu_rdy);
        end
        tick(); expect_wr("full_w1", 4'd6, 6'h22);
        tick(); expect_wr("full_w2", 4'd7, 6'h33);
        tick(); expect_wr("full_w3", 4'd8, 6'h3C);
        tick(); expect_nowr("full_dropped");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL full_busy: got busy=%b, want 0", busy);
        end
        hblank = 1'b0;
    endtask

    task automatic test_blank_toggle();
        int exp_i = 0;
        int cyc = 0;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        while (exp_i < 16 && cyc < 200) begin
            hblank = ((cyc / 3) % 2) == 0;
            tick();
            if (hblank) begin
                expect_wr("toggle_wr", 4'(exp_i), def_tab[exp_i]);
                exp_i++;
            end else begin
                expect_nowr("toggle_gap");
            end
            cyc++;
        end
        checks++;
        if (exp_i != 16 || busy !== 1'b0) begin
            errors++;
            $display("FAIL toggle_end: got writes=%0d busy=%b, want 16 busy=0", exp_i, busy);
        end
        hblank = 1'b0;
    endtask

    task automatic test_restart();
        vblank = 1'b1;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 2) begin
                cpu_wr = 1'b1; cpu_idx = 4'd2; cpu_data = 6'h01;
            end
            tick();
            cpu_wr = 1'b0;
            expect_wr("restart_pre", 4'(i), def_tab[i]);
        end
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_wr("restart_seq", 4'(i), def_tab[i]);
        end
        tick();
        expect_wr("restart_cpu", 4'd2, 6'h01);
        tick();
        expect_nowr("restart_done");
        vblank = 1'b0;
    endtask

    task automatic test_async_reset();
        push(4'd1, 6'h05);
        push(4'd2, 6'h06);
        push(4'd3, 6'h07);
        vblank = 1'b1;
        tick();
        expect_wr("rst_drain", 4'd1, 6'h05);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pal_wr !== 1'b0 || pal_idx !== 4'd0 || pal_data !== 6'd0 || pal_sel !== 1'b0 ||
            cpu_rdy !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got wr=%b idx=%0d data=%h sel=%b rdy=%b busy=%b, want 0 0 00 0 1 1",
                     pal_wr, pal_idx, pal_data, pal_sel, cpu_rdy, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_wr("rst_reinit", 4'(i), def_tab[i]);
        end
        tick();
        expect_nowr("rst_fifo_empty");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy: got busy=%b, want 0", busy);
        end
        vblank = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init_seq();
        test_cpu_blank();
        test_fifo_full();
        test_blank_toggle();
        test_restart();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
